// File: rtl/decomp_pkg.sv
// Shared state encoding, width defaults and InWord field layout for the RLE decompressor.
package decomp_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_RUN_W  = 8;

    // InWord = {RunLen, Pixel}: the pixel occupies the low bits and RunLen sits directly above it.
    localparam int PIX_LSB = 0;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EXPAND,
        DONE
    } state_t;

endpackage

// File: rtl/rle_run_counter.sv
// Loadable down-counter; zero_o is high when the count will be zero after the coming edge.
module rle_run_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_d == '0);

endmodule

// File: rtl/rle_decompress_addr_gen.sv
// Expands {RunLen,Pixel} words into consecutive RAM writes from BaseAddress.
// Define DECOMP_CHECKSUM_EN to add the 16-bit Checksum output of all written pixels.
module rle_decompress_addr_gen
    import decomp_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RUN_W  = DEF_RUN_W
) (
    input  logic                    Clk,
    input  logic                    ResetN,
    input  logic                    Start,
    input  logic                    Abort,
    input  logic [ADDR_W-1:0]       BaseAddress,
    input  logic [ADDR_W-1:0]       TotalCount,
    input  logic                    InValid,
    input  logic [RUN_W+DATA_W-1:0] InWord,
    output logic                    InReady,
    output logic [ADDR_W-1:0]       AddressInDecompressed,
    output logic [DATA_W-1:0]       DataToRAM,
    output logic                    WriteEnable,
    output logic                    Busy,
    output logic                    Done,
    output logic                    Overrun
`ifdef DECOMP_CHECKSUM_EN
    ,
    output logic [15:0]             Checksum
`endif
);

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] pix_q;
    logic              we_q;
    logic              ready_q;
    logic              busy_q;
    logic              done_q;
    logic              overrun_q;

    logic [DATA_W-1:0] word_pix;
    logic [RUN_W-1:0]  word_run;
    logic              start_ok;
    logic              handshake;
    logic              expanding;
    logic              run_zero;
    logic              rem_zero;

    assign word_pix  = InWord[PIX_LSB +: DATA_W];
    assign word_run  = InWord[PIX_LSB + DATA_W +: RUN_W];
    assign start_ok  = Start && !Abort && (state_q == IDLE);
    assign handshake = InValid && ready_q && !Abort;
    assign expanding = (state_q == EXPAND);
    assign addr_d    = addr_q + ADDR_W'(1);

    rle_run_counter #(.W(RUN_W)) u_run_cnt (
        .clk_i      (Clk),
        .rst_ni     (ResetN),
        .load_i     (handshake),
        .load_val_i (word_run),
        .dec_i      (expanding),
        .zero_o     (run_zero)
    );

    rle_run_counter #(.W(ADDR_W)) u_rem_cnt (
        .clk_i      (Clk),
        .rst_ni     (ResetN),
        .load_i     (start_ok),
        .load_val_i (TotalCount),
        .dec_i      (expanding),
        .zero_o     (rem_zero)
    );

    // The zero flags look at the post-write count, so EXPAND decides its exit on the current write.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            pix_q     <= '0;
            we_q      <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else if (Abort) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        addr_q    <= BaseAddress;
                        overrun_q <= 1'b0;
                        busy_q    <= 1'b1;
                        if (TotalCount == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= FETCH;
                            ready_q <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (handshake) begin
                        pix_q <= word_pix;
                        if (word_run != '0) begin
                            state_q <= EXPAND;
                            ready_q <= 1'b0;
                            we_q    <= 1'b1;
                        end
                    end
                end
                EXPAND: begin
                    addr_q <= addr_d;
                    if (rem_zero) begin
                        state_q <= DONE;
                        we_q    <= 1'b0;
                        done_q  <= 1'b1;
                        if (!run_zero) begin
                            overrun_q <= 1'b1;
                        end
                    end else if (run_zero) begin
                        state_q <= FETCH;
                        we_q    <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign InReady               = ready_q;
    assign AddressInDecompressed = addr_q;
    assign DataToRAM             = pix_q;
    assign WriteEnable           = we_q;
    assign Busy                  = busy_q;
    assign Done                  = done_q;
    assign Overrun               = overrun_q;

`ifdef DECOMP_CHECKSUM_EN
    logic [15:0] checksum_q;

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            checksum_q <= '0;
        end else if (start_ok) begin
            checksum_q <= '0;
        end else if (we_q) begin
            checksum_q <= checksum_q + 16'(pix_q);
        end
    end

    assign Checksum = checksum_q;
`endif

endmodule

// File: tb/tb_rle_decompress_addr_gen.sv
// Randomized bench for rle_decompress_addr_gen: a per-cycle behavioural model of the write
// stream plus literal expectations for the directed cases.
module tb_rle_decompress_addr_gen;

    logic        Clk = 1'b0;
    logic        ResetN = 1'b0;
    logic        Start = 1'b0;
    logic        Abort = 1'b0;
    logic [15:0] BaseAddress = 16'h0;
    logic [15:0] TotalCount = 16'h0;
    logic        InValid = 1'b0;
    logic [15:0] InWord = 16'h0;
    logic        InReady;
    logic [15:0] AddressInDecompressed;
    logic [7:0]  DataToRAM;
    logic        WriteEnable;
    logic        Busy;
    logic        Done;
    logic        Overrun;
`ifdef DECOMP_CHECKSUM_EN
    logic [15:0] Checksum;
`endif

    rle_decompress_addr_gen dut (
        .Clk                   (Clk),
        .ResetN                (ResetN),
        .Start                 (Start),
        .Abort                 (Abort),
        .BaseAddress           (BaseAddress),
        .TotalCount            (TotalCount),
        .InValid               (InValid),
        .InWord                (InWord),
        .InReady               (InReady),
        .AddressInDecompressed (AddressInDecompressed),
        .DataToRAM             (DataToRAM),
        .WriteEnable           (WriteEnable),
        .Busy                  (Busy),
        .Done                  (Done),
        .Overrun               (Overrun)
`ifdef DECOMP_CHECKSUM_EN
        ,
        .Checksum              (Checksum)
`endif
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    function automatic void chk(string nm, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endfunction

    // Behavioural model: what the job still owes (remaining pixels, writes of the current run).
    int          m_rem = 0;
    int          m_burst = 0;
    bit          m_fetch = 0;
    bit          m_done = 0;
    bit          m_ovr = 0;
    bit          m_ovr_pend = 0;
    logic [15:0] m_addr = 16'h0;
    logic [15:0] m_csum = 16'h0;
    logic [7:0]  m_pix = 8'h0;

    int          done_cnt = 0;
    int          wr_cnt = 0;
    logic [15:0] wr_addr [256];
    logic [7:0]  wr_data [256];
    logic [15:0] wq [$];

    always @(negedge Clk) begin : monitor
        int run;
        bit busy_now;
        bit nd;
        if (!ResetN) begin
            chk("rst_we", WriteEnable, 0);
            chk("rst_ready", InReady, 0);
            chk("rst_busy", Busy, 0);
            chk("rst_done", Done, 0);
            chk("rst_overrun", Overrun, 0);
            chk("rst_addr", AddressInDecompressed, 0);
            chk("rst_data", DataToRAM, 0);
            m_rem = 0; m_burst = 0; m_fetch = 0; m_done = 0;
            m_ovr = 0; m_ovr_pend = 0; m_addr = 0; m_csum = 0; m_pix = 0;
        end else begin
            busy_now = m_fetch || (m_burst > 0) || m_done;
            chk("we", WriteEnable, (m_burst > 0) ? 1 : 0);
            chk("in_ready", InReady, m_fetch ? 1 : 0);
            chk("busy", Busy, busy_now ? 1 : 0);
            chk("done", Done, m_done ? 1 : 0);
            chk("overrun", Overrun, m_ovr ? 1 : 0);
            if (m_burst > 0) begin
                chk("addr", AddressInDecompressed, m_addr);
                chk("data", DataToRAM, m_pix);
            end
`ifdef DECOMP_CHECKSUM_EN
            if (m_done) chk("checksum", Checksum, m_csum);
`endif
            if (WriteEnable) begin
                if (wr_cnt < 256) begin
                    wr_addr[wr_cnt] = AddressInDecompressed;
                    wr_data[wr_cnt] = DataToRAM;
                end
                wr_cnt++;
            end
            if (Done) done_cnt++;

            nd = 0;
            if (m_burst > 0) begin
                m_csum = m_csum + {8'h00, m_pix};
                m_addr = m_addr + 16'h1;
                m_burst--;
                m_rem--;
                if (m_rem == 0) begin
                    nd = 1;
                    if (m_ovr_pend && !Abort) m_ovr = 1;
                end else if (m_burst == 0) begin
                    m_fetch = 1;
                end
            end else if (m_fetch && InValid && !Abort) begin
                run = int'(InWord[15:8]);
                if (run > 0) begin
                    m_pix      = InWord[7:0];
                    m_burst    = (run < m_rem) ? run : m_rem;
                    m_ovr_pend = (run > m_rem);
                    m_fetch    = 0;
                end
            end
            if (!Abort && Start && !busy_now) begin
                m_addr     = BaseAddress;
                m_rem      = int'(TotalCount);
                m_csum     = 16'h0;
                m_ovr      = 0;
                m_ovr_pend = 0;
                if (TotalCount == 16'h0) nd = 1;
                else m_fetch = 1;
            end
            m_done = Abort ? 0 : nd;
            if (Abort) begin
                m_fetch = 0;
                m_burst = 0;
            end
        end
    end

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] base, input logic [15:0] total);
        Start = 1'b1;
        BaseAddress = base;
        TotalCount = total;
        cyc();
        Start = 1'b0;
    endtask

    // Runs one job from the words in wq; optionally pulses a stray Start while busy.
    task automatic run_job(input string nm, input logic [15:0] base, input logic [15:0] total,
                           input int pct, input bit spur);
        int d0;
        bit hs;
        bit got;
        d0 = done_cnt;
        wr_cnt = 0;
        got = 0;
        do_start(base, total);
        for (int i = 0; i < 3000; i++) begin
            if (done_cnt != d0) begin
                got = 1;
                break;
            end
            Start = spur && (i == 3);
            if (Start) begin
                BaseAddress = 16'h7777;
                TotalCount = 16'd3;
            end
            InValid = (wq.size() > 0) && ($urandom_range(99) < pct);
            InWord = (wq.size() > 0) ? wq[0] : 16'h0;
            hs = InValid && InReady;
            cyc();
            if (hs) void'(wq.pop_front());
        end
        Start = 1'b0;
        InValid = 1'b0;
        if (!got) chk({nm, "_timeout"}, 0, 1);
        chk({nm, "_done_pulses"}, done_cnt - d0, 1);
        $display("job %s base=%h total=%0d writes=%0d overrun=%0b", nm, base, total, wr_cnt, Overrun);
        wq.delete();
        cyc();
    endtask

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int d0;
        int sum;
        int rem;
        int r;
        int p;
        logic [15:0] es;
        logic [15:0] tot;
        repeat (3) @(posedge Clk);
        #1 ResetN = 1'b1;
        cyc();

        // T1: two runs, with a stray Start while busy that must be ignored
        wq.push_back(16'h03AA);
        wq.push_back(16'h02BB);
        run_job("T1", 16'h0100, 16'd5, 100, 1);
        chk("t1_writes", wr_cnt, 5);
        chk("t1_addr0", wr_addr[0], 16'h0100);
        chk("t1_data2", wr_data[2], 8'hAA);
        chk("t1_addr4", wr_addr[4], 16'h0104);
        chk("t1_data4", wr_data[4], 8'hBB);
        chk("t1_overrun", Overrun, 0);
`ifdef DECOMP_CHECKSUM_EN
        chk("t1_checksum", Checksum, 16'h0374);
`endif

        // T2: run longer than the remaining count
        wq.push_back(16'h0611);
        run_job("T2", 16'h0400, 16'd4, 100, 0);
        chk("t2_writes", wr_cnt, 4);
        chk("t2_addr3", wr_addr[3], 16'h0403);
        chk("t2_overrun", Overrun, 1);
        InValid = 1'b1;
        repeat (3) cyc();
        chk("t2_ready_after", InReady, 0);
        InValid = 1'b0;

        // T3: address wrap
        wq.push_back(16'h0422);
        run_job("T3", 16'hFFFE, 16'd4, 100, 0);
        chk("t3_addr0", wr_addr[0], 16'hFFFE);
        chk("t3_addr1", wr_addr[1], 16'hFFFF);
        chk("t3_addr2", wr_addr[2], 16'h0000);
        chk("t3_addr3", wr_addr[3], 16'h0001);

        // T4: zero-length run is a no-op
        wq.push_back(16'h0033);
        wq.push_back(16'h0244);
        run_job("T4", 16'h0500, 16'd2, 100, 0);
        chk("t4_writes", wr_cnt, 2);
        chk("t4_data0", wr_data[0], 8'h44);
        chk("t4_addr1", wr_addr[1], 16'h0501);
        chk("t4_overrun", Overrun, 0);

        // TotalCount == 0 goes straight to Done
        run_job("T0", 16'h1234, 16'd0, 100, 0);
        chk("t0_writes", wr_cnt, 0);

        // T5: Abort during the second write of a 10-pixel run
        d0 = done_cnt;
        wr_cnt = 0;
        do_start(16'h0200, 16'd20);
        InValid = 1'b1;
        InWord = 16'h0A55;
        cyc();
        InValid = 1'b0;
        cyc();
        Abort = 1'b1;
        cyc();
        Abort = 1'b0;
        chk("t5_we_after_abort", WriteEnable, 0);
        repeat (3) cyc();
        chk("t5_writes", wr_cnt, 2);
        chk("t5_busy", Busy, 0);
        chk("t5_no_done", done_cnt - d0, 0);
        $display("job T5 abort base=0200 writes=%0d", wr_cnt);
        wq.push_back(16'h0466);
        wq.push_back(16'h0177);
        run_job("T5b", 16'h0210, 16'd5, 100, 0);
        chk("t5b_data4", wr_data[4], 8'h77);
        chk("t5b_addr4", wr_addr[4], 16'h0214);

        // Start and Abort together: Abort wins
        Start = 1'b1;
        Abort = 1'b1;
        BaseAddress = 16'h0900;
        TotalCount = 16'd5;
        cyc();
        Start = 1'b0;
        Abort = 1'b0;
        repeat (2) cyc();
        chk("sa_busy", Busy, 0);
        chk("sa_ready", InReady, 0);
        $display("job start+abort busy=%0b", Busy);

        // T6: 64 pixels of random runs with 50% InValid gaps
        sum = 0;
        es = 16'h0;
        rem = 64;
        while (sum < 64) begin
            r = $urandom_range(12);
            p = $urandom_range(255);
            wq.push_back({r[7:0], p[7:0]});
            es = es + 16'(p * ((r < rem) ? r : rem));
            rem = rem - ((r < rem) ? r : rem);
            sum += r;
        end
        run_job("T6", 16'($urandom), 16'd64, 50, 0);
        chk("t6_writes", wr_cnt, 64);
`ifdef DECOMP_CHECKSUM_EN
        chk("t6_checksum", Checksum, es);
`endif
        $display("job T6 expected checksum=%h", es);

        // Further random jobs
        for (int j = 0; j < 12; j++) begin
            tot = 16'($urandom_range(40));
            sum = 0;
            while (sum < int'(tot)) begin
                r = $urandom_range(9);
                p = $urandom_range(255);
                wq.push_back({r[7:0], p[7:0]});
                sum += r;
            end
            run_job("RND", 16'($urandom), tot, $urandom_range(30, 100), 0);
            chk("rnd_writes", wr_cnt, tot);
        end

        // Reset asserted mid-run
        do_start(16'h0300, 16'd8);
        InValid = 1'b1;
        InWord = 16'h0899;
        cyc();
        InValid = 1'b0;
        cyc();
        ResetN = 1'b0;
        #1;
        chk("arst_we", WriteEnable, 0);
        chk("arst_busy", Busy, 0);
        cyc();
        ResetN = 1'b1;
        repeat (2) cyc();
        $display("job reset mid-run busy=%0b", Busy);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
